// File: rtl/vc_pipe_ctrl_chain_pkg.sv
// Shared types and constants for the pipeline valid/stall/squash controller.
// The perf counter width default lives here for the VC_PIPE_CTRL_PERF_EN build.
package vc_pipe_ctrl_chain_pkg;

  localparam int VC_PERF_CNT_W = 16;

  // Everything one slice reports back to the chain
  typedef struct packed {
    logic val;
    logic reg_en;
    logic go;
    logic prev_stall;
    logic prev_squash;
  } stage_ctl_t;

endpackage

// File: rtl/vc_EnResetReg.sv
// Enable register with synchronous active-high reset.
module vc_EnResetReg #(
  parameter int           W           = 1,
  parameter logic [W-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= RESET_VALUE;
    else if (en) q <= d;
  end

endmodule

// File: rtl/vc_pipe_ctrl_stage.sv
// One slice of the pipeline controller: valid bit plus local stall/squash
// aggregation toward the upstream stage.
module vc_pipe_ctrl_stage
  import vc_pipe_ctrl_chain_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       prev_val,
  input  logic       next_stall,
  input  logic       next_squash,
  input  logic       curr_stall,
  input  logic       curr_squash,
  output stage_ctl_t ctl
);

  logic v;
  logic pstall;
  logic reg_en_v;

  // Bubbles never forward a stall; a downstream squash overrides it
  assign pstall   = (next_stall || curr_stall) && v && !next_squash;
  assign reg_en_v = !pstall || next_squash;

  vc_EnResetReg #(.W(1), .RESET_VALUE(1'b0)) u_val (
    .clk   (clk),
    .reset (reset),
    .en    (reg_en_v),
    .d     (prev_val),
    .q     (v)
  );

  always_comb begin
    ctl             = '0;
    ctl.val         = v;
    ctl.prev_stall  = pstall;
    ctl.reg_en      = (!pstall && prev_val) || next_squash;
    ctl.go          = v && !next_squash && !next_stall && !curr_stall;
    ctl.prev_squash = next_squash || (curr_squash && !next_stall && !curr_stall);
  end

endmodule

// File: rtl/vc_pipe_ctrl_chain.sv
// N-stage in-order pipeline valid/stall/squash controller with flush and
// occupancy. Define VC_PIPE_CTRL_PERF_EN for saturating stall/squash counters.
module vc_pipe_ctrl_chain
  import vc_pipe_ctrl_chain_pkg::*;
#(
  parameter int NSTAGES = 5,
  parameter int OCC_W   = 3
`ifdef VC_PIPE_CTRL_PERF_EN
  ,
  parameter int CNT_W   = VC_PERF_CNT_W
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_stall,
  output logic               in_squash,
  input  logic [NSTAGES-1:0] stage_stall,
  input  logic [NSTAGES-1:0] stage_squash,
  output logic [NSTAGES-1:0] stage_val,
  output logic [NSTAGES-1:0] stage_reg_en,
  output logic [NSTAGES-1:0] stage_go,
  output logic               out_val,
  input  logic               out_stall,
  input  logic               out_squash,
  input  logic               flush,
  output logic [OCC_W-1:0]   occupancy
`ifdef VC_PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   squash_cycles
`endif
);

  if ((2 ** OCC_W) <= NSTAGES) begin : g_bad_occ_w
    $error("OCC_W too narrow for NSTAGES");
  end

  // Index i is stage i's input side; index NSTAGES is the sink boundary
  logic [NSTAGES:0] chain_val;
  logic [NSTAGES:0] chain_stall;
  logic [NSTAGES:0] chain_squash;
  logic             clr;

  stage_ctl_t ctl [NSTAGES];

  assign clr                   = reset || flush;
  assign chain_val[0]          = in_val;
  assign chain_stall[NSTAGES]  = out_stall;
  assign chain_squash[NSTAGES] = out_squash;

  for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
    vc_pipe_ctrl_stage u_stage (
      .clk         (clk),
      .reset       (clr),
      .prev_val    (chain_val[i]),
      .next_stall  (chain_stall[i+1]),
      .next_squash (chain_squash[i+1]),
      .curr_stall  (stage_stall[i]),
      .curr_squash (stage_squash[i]),
      .ctl         (ctl[i])
    );

    assign chain_val[i+1]  = ctl[i].go;
    assign chain_stall[i]  = ctl[i].prev_stall;
    assign chain_squash[i] = ctl[i].prev_squash;
    assign stage_val[i]    = ctl[i].val;
    assign stage_reg_en[i] = ctl[i].reg_en;
    assign stage_go[i]     = ctl[i].go;
  end

  assign in_stall  = chain_stall[0];
  assign in_squash = chain_squash[0];
  assign out_val   = chain_val[NSTAGES];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NSTAGES; i++)
      occupancy = occupancy + OCC_W'(stage_val[i]);
  end

`ifdef VC_PIPE_CTRL_PERF_EN
  // Saturating counters; flush deliberately leaves them alone
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles  <= '0;
      squash_cycles <= '0;
    end else begin
      if (in_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (in_squash && (squash_cycles != '1))
        squash_cycles <= squash_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_pipe_ctrl_chain.sv
// Scoreboard bench for vc_pipe_ctrl_chain (NSTAGES=5); counter checks are
// active when VC_PIPE_CTRL_PERF_EN is defined.
module tb_vc_pipe_ctrl_chain;

  localparam int NS = 5;
`ifdef VC_PIPE_CTRL_PERF_EN
  localparam int CNT_W = 4;
`endif

  logic          clk = 1'b0;
  logic          reset, in_val, in_stall, in_squash, out_val, out_stall, out_squash, flush;
  logic [NS-1:0] stage_stall, stage_squash, stage_val, stage_reg_en, stage_go;
  logic [2:0]    occupancy;
`ifdef VC_PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles, squash_cycles;
`endif

  always #5 clk = ~clk;

  vc_pipe_ctrl_chain #(
    .NSTAGES (NS),
    .OCC_W   (3)
`ifdef VC_PIPE_CTRL_PERF_EN
    ,
    .CNT_W   (CNT_W)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_val       (in_val),
    .in_stall     (in_stall),
    .in_squash    (in_squash),
    .stage_stall  (stage_stall),
    .stage_squash (stage_squash),
    .stage_val    (stage_val),
    .stage_reg_en (stage_reg_en),
    .stage_go     (stage_go),
    .out_val      (out_val),
    .out_stall    (out_stall),
    .out_squash   (out_squash),
    .flush        (flush),
    .occupancy    (occupancy)
`ifdef VC_PIPE_CTRL_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .squash_cycles (squash_cycles)
`endif
  );

  typedef struct {
    string         name;
    logic [NS-1:0] val, go, en;
    logic          ist, isq, ov;
    logic [2:0]    occ;
    bit            pchk;
    int            scnt, qcnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle with a pending entry is a response
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.name, "stage_val",    32'(stage_val),    32'(e.val));
      cmp(e.name, "stage_go",     32'(stage_go),     32'(e.go));
      cmp(e.name, "stage_reg_en", 32'(stage_reg_en), 32'(e.en));
      cmp(e.name, "in_stall",     32'(in_stall),     32'(e.ist));
      cmp(e.name, "in_squash",    32'(in_squash),    32'(e.isq));
      cmp(e.name, "out_val",      32'(out_val),      32'(e.ov));
      cmp(e.name, "occupancy",    32'(occupancy),    32'(e.occ));
`ifdef VC_PIPE_CTRL_PERF_EN
      if (e.pchk) begin
        cmp(e.name, "stall_cycles",  32'(stall_cycles),  32'(e.scnt));
        cmp(e.name, "squash_cycles", 32'(squash_cycles), 32'(e.qcnt));
      end
`endif
    end
  end

  task automatic step(input string nm, input logic iv, input logic [NS-1:0] st, input logic [NS-1:0] sq,
                      input logic os, input logic oq, input logic fl, input logic rs, input bit chk,
                      input logic [NS-1:0] ev, input logic [NS-1:0] eg, input logic [NS-1:0] een,
                      input logic eis, input logic eisq, input logic eov, input logic [2:0] eocc,
                      input bit pc = 1'b0, input int sc = 0, input int qc = 0);
    @(posedge clk); #1;
    in_val = iv; stage_stall = st; stage_squash = sq;
    out_stall = os; out_squash = oq; flush = fl; reset = rs;
    if (chk) begin
      exp_t e;
      e.name = nm; e.val = ev; e.go = eg; e.en = een;
      e.ist = eis; e.isq = eisq; e.ov = eov; e.occ = eocc;
      e.pchk = pc; e.scnt = sc; e.qcnt = qc;
      sb.push_back(e);
    end
  endtask

  task automatic drv(input logic iv, input logic os, input logic rs);
    step("drv", iv, '0, '0, os, 1'b0, 1'b0, rs, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_val = 1'b0; stage_stall = '0; stage_squash = '0;
    out_stall = 1'b0; out_squash = 1'b0; flush = 1'b0;

    drv(0, 0, 1);
    // Reset cycle: valids clear, squash from an idle stage still reaches the source
    step("rst", 0, 5'b00000, 5'b00100, 0, 0, 0, 1, 1, 5'b00000, 5'b00000, 5'b00011, 0, 1, 0, 3'd0);

    // Fill with in_val every cycle
    step("fill0", 1, '0, '0, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b00001, 0, 0, 0, 3'd0);
    step("fill1", 1, '0, '0, 0, 0, 0, 0, 1, 5'b00001, 5'b00001, 5'b00011, 0, 0, 0, 3'd1);
    step("fill2", 1, '0, '0, 0, 0, 0, 0, 1, 5'b00011, 5'b00011, 5'b00111, 0, 0, 0, 3'd2);
    step("fill3", 1, '0, '0, 0, 0, 0, 0, 1, 5'b00111, 5'b00111, 5'b01111, 0, 0, 0, 3'd3);
    step("fill4", 1, '0, '0, 0, 0, 0, 0, 1, 5'b01111, 5'b01111, 5'b11111, 0, 0, 0, 3'd4);
    step("fill5", 1, '0, '0, 0, 0, 0, 0, 1, 5'b11111, 5'b11111, 5'b11111, 0, 0, 1, 3'd5);

    // Stage 2 stalls for three cycles on a full pipe, then refill
    step("stl0", 1, 5'b00100, '0, 0, 0, 0, 0, 1, 5'b11111, 5'b11000, 5'b10000, 1, 0, 1, 3'd5);
    step("stl1", 1, 5'b00100, '0, 0, 0, 0, 0, 1, 5'b10111, 5'b10000, 5'b00000, 1, 0, 1, 3'd4);
    step("stl2", 1, 5'b00100, '0, 0, 0, 0, 0, 1, 5'b00111, 5'b00000, 5'b00000, 1, 0, 0, 3'd3);
    step("stl3", 1, '0, '0, 0, 0, 0, 0, 1, 5'b00111, 5'b00111, 5'b01111, 0, 0, 0, 3'd3);
    step("stl4", 1, '0, '0, 0, 0, 0, 0, 1, 5'b01111, 5'b01111, 5'b11111, 0, 0, 0, 3'd4);
    step("stl5", 1, '0, '0, 0, 0, 0, 0, 1, 5'b11111, 5'b11111, 5'b11111, 0, 0, 1, 3'd5);

    // Squash at stage 3 overrides the stall at stage 2
    step("sqs0", 1, 5'b00100, 5'b01000, 0, 0, 0, 0, 1, 5'b11111, 5'b11000, 5'b10111, 0, 1, 1, 3'd5);
    step("sqs1", 1, '0, '0, 0, 0, 0, 0, 1, 5'b10001, 5'b10001, 5'b00011, 0, 0, 1, 3'd2);

    // Flush a full pipe, then refill from stage 0
    repeat (5) drv(1, 0, 0);
    step("fls0", 1, '0, '0, 0, 0, 1, 0, 1, 5'b11111, 5'b11111, 5'b11111, 0, 0, 1, 3'd5);
    step("fls1", 1, '0, '0, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b00001, 0, 0, 0, 3'd0);
    step("fls2", 1, '0, '0, 0, 0, 0, 0, 1, 5'b00001, 5'b00001, 5'b00011, 0, 0, 0, 3'd1);

    // Stall on a bubble at stage 2 is not forwarded
    drv(0, 0, 1);
    drv(1, 0, 0); drv(0, 0, 0); drv(1, 0, 0); drv(1, 0, 0);
    step("bub0", 1, 5'b00100, '0, 0, 0, 0, 0, 1, 5'b01011, 5'b01011, 5'b10111, 0, 0, 0, 3'd3);
    step("bub1", 1, '0, '0, 0, 0, 0, 0, 1, 5'b10111, 5'b10111, 5'b01111, 0, 0, 1, 3'd4);

    // Squash from the sink kills every stage
    drv(1, 0, 0);
    step("osq0", 1, '0, '0, 0, 1, 0, 0, 1, 5'b11111, 5'b00000, 5'b11111, 0, 1, 0, 3'd5);
    step("osq1", 0, '0, '0, 0, 0, 0, 0, 1, 5'b00001, 5'b00001, 5'b00010, 0, 0, 0, 3'd1);

    // Sink stall held 20 cycles; counters (when built) saturate, reset clears
    drv(0, 0, 1);
    repeat (5) drv(1, 0, 0);
    for (int k = 0; k < 20; k++)
      step("sat", 1, '0, '0, 1, 0, 0, 0, 1, 5'b11111, 5'b00000, 5'b00000, 1, 0, 0, 3'd5,
           1'b1, (k > 15) ? 15 : k, 0);
    step("prst0", 1, '0, '0, 1, 0, 0, 1, 1, 5'b11111, 5'b00000, 5'b00000, 1, 0, 0, 3'd5, 1'b1, 15, 0);
    step("prst1", 0, '0, '0, 1, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 3'd0, 1'b1, 0, 0);
    step("psq0",  0, '0, '0, 0, 1, 0, 0, 1, 5'b00000, 5'b00000, 5'b11111, 0, 1, 0, 3'd0, 1'b1, 0, 0);
    step("psq1",  0, '0, '0, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 3'd0, 1'b1, 0, 1);

    for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
